// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART operand receiver.
//   rx_state_t     : receiver FSM states
//   UART_DATA_BITS : data bits per 8N1 frame
//   OPERAND_BYTES  : bytes per operand pair (two 32-bit operands)
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } rx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int OPERAND_BYTES  = 8;

endpackage

// File: rtl/uart_operand_rx_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// 1-bit two-flop synchronizer. Resets to 1 so an idle-high serial line does
// not look like a start bit while the design comes out of reset.
//   clk : destination clock
//   rst : asynchronous, active-high reset
//   d_i : asynchronous input
//   q_o : synchronized output
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_q <= 1'b1;
            ff2_q <= 1'b1;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/uart_operand_rx.sv
// ---------------------------------------------------------------------------
// uart_operand_rx
// 8N1 UART receiver feeding the FPU operand register stage. Each good byte is
// presented on `number` with its index on `partition` (0-3 operand 1, 4-7
// operand 2, LSB byte first) and committed with a 1-cycle active-low `enter`.
//   clk            : system clock
//   rst            : asynchronous, active-high reset
//   rx             : serial line, idle high, asynchronous to clk
//   number         : last good byte (held between strobes)
//   partition      : index of the byte on `number`
//   enter          : active-low commit strobe, 1 cycle per good byte
//   operands_ready : 1-cycle pulse with the strobe of index 7
//   frame_err      : 1-cycle pulse when a stop bit is sampled low
// ---------------------------------------------------------------------------
module uart_operand_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] number,
    output logic [2:0] partition,
    output logic       enter,
    output logic       operands_ready,
    output logic       frame_err
);

    localparam int          BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0]  IDX_LAST  = 3'(OPERAND_BYTES - 1);

    // Idle timeout limit in clocks; width covers the TIMEOUT_BITS=0 case too.
    localparam int unsigned TL        = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int          IW        = $clog2(TL + 2);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TL - 1);

    logic rx_s;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    rx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q,  baud_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q,   idx_d;
    logic [IW-1:0] idle_q,  idle_d;
    logic [7:0]    num_q,   num_d;
    logic [2:0]    part_q,  part_d;
    logic          enter_q, enter_d;
    logic          rdy_q,   rdy_d;
    logic          ferr_q,  ferr_d;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        idle_d  = '0;       // idle counter only survives in IDLE with rx high
        num_d   = num_q;
        part_d  = part_q;
        enter_d = 1'b1;
        rdy_d   = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = '0;
                end else if (TIMEOUT_BITS > 0 && idx_q != 3'd0) begin
                    // Abandon a partial operand sequence after a long quiet line.
                    if (idle_q == IDLE_LAST) begin
                        idx_d = 3'd0;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end
            end
            START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    state_d = rx_s ? IDLE : DATA;   // high at mid-start = glitch
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[7:1]};  // LSB arrives first
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == BIT_LAST) state_d = STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (rx_s) begin
                        num_d   = shift_q;
                        part_d  = idx_q;
                        enter_d = 1'b0;
                        rdy_d   = (idx_q == IDX_LAST);
                        idx_d   = idx_q + 3'd1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RECOVER;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            RECOVER: begin
                // A line stuck low must not be mistaken for a run of start bits.
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            idle_q  <= '0;
            num_q   <= '0;
            part_q  <= '0;
            enter_q <= 1'b1;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            num_q   <= num_d;
            part_q  <= part_d;
            enter_q <= enter_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
        end
    end

    assign number         = num_q;
    assign partition      = part_q;
    assign enter          = enter_q;
    assign operands_ready = rdy_q;
    assign frame_err      = ferr_q;

endmodule

// File: tb/tb_uart_operand_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_operand_rx
// Directed bench for uart_operand_rx with CLKS_PER_BIT=16, TIMEOUT_BITS=16.
// A monitor logs every enter strobe; the main sequence drives frames and
// compares logged strobes against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_operand_rx;
    import uart_pkg::*;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] number;
    logic [2:0] partition;
    logic       enter;
    logic       operands_ready;
    logic       frame_err;

    always #5 clk = ~clk;

    uart_operand_rx #(
        .CLKS_PER_BIT (16),
        .TIMEOUT_BITS (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx             (rx),
        .number         (number),
        .partition      (partition),
        .enter          (enter),
        .operands_ready (operands_ready),
        .frame_err      (frame_err)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] q_num [$];
    logic [2:0] q_part[$];
    logic       q_rdy [$];
    time        q_t   [$];
    int  enter_wide = 0, ferr_cnt = 0, ferr_wide = 0, clash = 0, orphan = 0;
    bit  enter_prev = 0, ferr_prev = 0;

    // Strobe monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!enter) begin
            q_num.push_back(number);
            q_part.push_back(partition);
            q_rdy.push_back(operands_ready);
            q_t.push_back($time);
            if (enter_prev) enter_wide++;
        end
        if (frame_err) begin
            ferr_cnt++;
            if (ferr_prev) ferr_wide++;
        end
        if (!enter && frame_err) clash++;
        if (operands_ready && enter) orphan++;
        enter_prev = !enter;
        ferr_prev  = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All drive tasks start and end on a falling edge.
    task automatic send_bit(input logic b);
        rx = b;
        repeat (C) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * C) @(negedge clk);
    endtask

    task automatic clear_log();
        q_num.delete(); q_part.delete(); q_rdy.delete(); q_t.delete();
        enter_wide = 0; ferr_cnt = 0; ferr_wide = 0; clash = 0; orphan = 0;
    endtask

    task automatic do_reset();
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_log();
    endtask

    logic [7:0] ops [8];
    time        t0;

    initial begin
        ops = '{8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h40};

        // Reset values
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_number", 32'(number), 32'h00);
        check("rst_partition", 32'(partition), 32'h0);
        check("rst_enter", 32'(enter), 32'h1);
        check("rst_ready", 32'(operands_ready), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_log();

        // Single byte. Start bit driven at negedge N0: rx_s low after P1,
        // START after P2, mid-start sample P10, data P26..P138, stop P154,
        // enter low seen at N155 -> 1550 ns.
        t0 = $time;
        send_byte(8'hA5, 1'b1);
        idle_bits(1);
        check("s1_count", 32'(q_num.size()), 32'd1);
        check("s1_number", 32'(q_num[0]), 32'hA5);
        check("s1_partition", 32'(q_part[0]), 32'h0);
        check("s1_ready", 32'(q_rdy[0]), 32'h0);
        check("s1_latency", 32'(q_t[0] - t0), 32'd1550);
        check("s1_width", 32'(enter_wide), 32'd0);
        check("s1_hold", 32'(number), 32'hA5);

        // Eight operand bytes back to back, then one more.
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(ops[i], 1'b1);
        send_byte(8'hC3, 1'b1);
        idle_bits(1);
        check("s2_count", 32'(q_num.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("s2_num%0d", i), 32'(q_num[i]), (i < 8) ? 32'(ops[i]) : 32'hC3);
            check($sformatf("s2_part%0d", i), 32'(q_part[i]), 32'(i % 8));
            check($sformatf("s2_rdy%0d", i), 32'(q_rdy[i]), (i == 7) ? 32'h1 : 32'h0);
        end
        check("s2_orphan_ready", 32'(orphan), 32'd0);
        check("s2_width", 32'(enter_wide), 32'd0);

        // Short low glitch on the line.
        do_reset();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * C) @(negedge clk);
        check("s3_no_enter", 32'(q_num.size()), 32'd0);
        check("s3_state", 32'(dut.state_q), 32'(IDLE));
        send_byte(8'h3C, 1'b1);
        idle_bits(1);
        check("s3_count", 32'(q_num.size()), 32'd1);
        check("s3_number", 32'(q_num[0]), 32'h3C);
        check("s3_partition", 32'(q_part[0]), 32'h0);

        // Framing error followed by a line held low for 40 bit periods.
        send_byte(8'h55, 1'b0);
        rx = 1'b0;
        repeat (40 * C) @(negedge clk);
        check("s4_ferr_count", 32'(ferr_cnt), 32'd1);
        check("s4_ferr_width", 32'(ferr_wide), 32'd0);
        check("s4_no_enter", 32'(q_num.size()), 32'd1);
        check("s4_state", 32'(dut.state_q), 32'(RECOVER));
        idle_bits(1);
        send_byte(8'h11, 1'b1);
        idle_bits(1);
        check("s4_count", 32'(q_num.size()), 32'd2);
        check("s4_number", 32'(q_num[1]), 32'h11);
        check("s4_partition", 32'(q_part[1]), 32'h1);
        check("s4_clash", 32'(clash), 32'd0);

        // Idle timeout: 17 bit periods abandons the partial sequence.
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        idle_bits(17);
        check("s5_hold_number", 32'(number), 32'h03);
        check("s5_hold_partition", 32'(partition), 32'h2);
        send_byte(8'h77, 1'b1);
        idle_bits(1);
        check("s5_number", 32'(q_num[3]), 32'h77);
        check("s5_partition_17", 32'(q_part[3]), 32'h0);

        // 15 bit periods stays below the limit.
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        idle_bits(15);
        send_byte(8'h77, 1'b1);
        idle_bits(1);
        check("s5_partition_15", 32'(q_part[3]), 32'h3);

        // Reset in the middle of the data bits.
        do_reset();
        send_byte(8'h42, 1'b1);
        idle_bits(1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        check("s6_number", 32'(number), 32'h00);
        check("s6_partition", 32'(partition), 32'h0);
        check("s6_enter", 32'(enter), 32'h1);
        check("s6_ready", 32'(operands_ready), 32'h0);
        check("s6_state", 32'(dut.state_q), 32'(IDLE));
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10 * C) @(negedge clk);
        check("s6_no_enter", 32'(q_num.size()), 32'd1);
        send_byte(8'h9A, 1'b1);
        idle_bits(1);
        check("s6_count", 32'(q_num.size()), 32'd2);
        check("s6_next_number", 32'(q_num[1]), 32'h9A);
        check("s6_next_partition", 32'(q_part[1]), 32'h0);
        check("s6_clash", 32'(clash), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
